// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side handshake bundle for mem_arbiter.
// master is the arbiter's view; slave is the view of the pipeline plus memory model.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [31:0]           if_rdata_o;
    logic                  if_valid_o;
    logic                  flush_i;
    logic                  dm_req_i;
    logic                  dm_we_i;
    logic                  dm_byte_i;
    logic [ADDR_WIDTH-1:0] dm_addr_i;
    logic [31:0]           dm_wdata_i;
    logic [31:0]           dm_rdata_o;
    logic                  dm_valid_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [31:0]           mem_rdata_i;
    logic                  stall_f_o;
    logic                  stall_m_o;

    modport master (
        input  if_req_i, if_addr_i, flush_i,
        input  dm_req_i, dm_we_i, dm_byte_i, dm_addr_i, dm_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_rdata_o, if_valid_o, dm_rdata_o, dm_valid_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output stall_f_o, stall_m_o
    );

    modport slave (
        output if_req_i, if_addr_i, flush_i,
        output dm_req_i, dm_we_i, dm_byte_i, dm_addr_i, dm_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_rdata_o, if_valid_o, dm_rdata_o, dm_valid_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  stall_f_o, stall_m_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the data stage,
// one transaction at a time, with fetch-flush discard and per-stage stall outputs.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, IF_REQ, IF_WAIT, DM_REQ, DM_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  last_dm_q, discard_q;
    logic [ADDR_WIDTH-3:0] waddr_q;
    logic [1:0]            lane_q;
    logic                  byte_q, we_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  pick_if, pick_dm, if_done, dm_done, set_discard;
    logic [7:0]            byte_sel;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pick_if     = 1'b0;
        pick_dm     = 1'b0;
        if_done     = 1'b0;
        dm_done     = 1'b0;
        set_discard = 1'b0;
        case (state_q)
            IDLE: begin
                // Data normally wins; fetch wins right after a data completion.
                if (bus.if_req_i && (!bus.dm_req_i || last_dm_q)) begin
                    pick_if = 1'b1;
                    state_d = IF_REQ;
                end else if (bus.dm_req_i) begin
                    pick_dm = 1'b1;
                    state_d = DM_REQ;
                end
            end
            IF_REQ: begin
                if (bus.mem_gnt_i) begin
                    state_d     = IF_WAIT;
                    set_discard = bus.flush_i;
                end else if (bus.flush_i) begin
                    state_d = IDLE;
                end
            end
            IF_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    if_done = 1'b1;
                    state_d = IDLE;
                end else begin
                    set_discard = bus.flush_i;
                end
            end
            DM_REQ: begin
                if (bus.mem_gnt_i) state_d = DM_WAIT;
            end
            DM_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    dm_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_dm_q <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            if (dm_done)      last_dm_q <= 1'b1;
            else if (if_done) last_dm_q <= 1'b0;
            if (if_done)          discard_q <= 1'b0;
            else if (set_discard) discard_q <= 1'b1;
        end
    end

    // Request fields are captured once at arbitration and held for the whole transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            waddr_q <= '0;
            lane_q  <= 2'b00;
            byte_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else if (pick_if) begin
            waddr_q <= bus.if_addr_i[ADDR_WIDTH-1:2];
            lane_q  <= bus.if_addr_i[1:0];
            byte_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b1111;
        end else if (pick_dm) begin
            waddr_q <= bus.dm_addr_i[ADDR_WIDTH-1:2];
            lane_q  <= bus.dm_addr_i[1:0];
            byte_q  <= bus.dm_byte_i;
            we_q    <= bus.dm_we_i;
            be_q    <= bus.dm_byte_i ? (4'b0001 << bus.dm_addr_i[1:0]) : 4'b1111;
            wdata_q <= bus.dm_byte_i ? {4{bus.dm_wdata_i[7:0]}} : bus.dm_wdata_i;
        end
    end

    assign byte_sel = bus.mem_rdata_i[{lane_q, 3'b000} +: 8];

    assign bus.mem_req_o   = (state_q == IF_REQ) || (state_q == DM_REQ);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_be_o    = be_q;
    assign bus.mem_addr_o  = {waddr_q, 2'b00};
    assign bus.mem_wdata_o = wdata_q;

    // A flush arriving with the response also kills the pulse.
    assign bus.if_valid_o  = if_done && !discard_q && !bus.flush_i;
    assign bus.dm_valid_o  = dm_done;
    assign bus.if_rdata_o  = bus.mem_rdata_i;
    assign bus.dm_rdata_o  = byte_q ? {24'h000000, byte_sel} : bus.mem_rdata_i;

    assign bus.stall_f_o   = bus.if_req_i && !bus.if_valid_o;
    assign bus.stall_m_o   = bus.dm_req_i && !bus.dm_valid_o;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: a per-cycle table plus a reset-mid-transaction sequence.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        ir;  logic [31:0] ia;  logic fl;
        logic        dr;  logic dw;  logic db;  logic [31:0] da;  logic [31:0] dd;
        logic        g;   logic rv;  logic [31:0] rd;
        logic        eq;  logic ew;  logic [3:0] ebe;  logic [31:0] ea;  logic [31:0] ewd;
        logic        eiv; logic edv; logic crd; logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.if_req_i     = v.ir;  bus.if_addr_i  = v.ia;  bus.flush_i    = v.fl;
        bus.dm_req_i     = v.dr;  bus.dm_we_i    = v.dw;  bus.dm_byte_i  = v.db;
        bus.dm_addr_i    = v.da;  bus.dm_wdata_i = v.dd;
        bus.mem_gnt_i    = v.g;   bus.mem_rvalid_i = v.rv; bus.mem_rdata_i = v.rd;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("r%0d.mem_req", i), {31'd0, bus.mem_req_o}, {31'd0, v.eq});
        chk($sformatf("r%0d.if_valid", i), {31'd0, bus.if_valid_o}, {31'd0, v.eiv});
        chk($sformatf("r%0d.dm_valid", i), {31'd0, bus.dm_valid_o}, {31'd0, v.edv});
        chk($sformatf("r%0d.stall_f", i), {31'd0, bus.stall_f_o}, {31'd0, v.ir & ~v.eiv});
        chk($sformatf("r%0d.stall_m", i), {31'd0, bus.stall_m_o}, {31'd0, v.dr & ~v.edv});
        if (v.eq) begin
            chk($sformatf("r%0d.mem_addr", i), bus.mem_addr_o, v.ea);
            chk($sformatf("r%0d.mem_be", i), {28'd0, bus.mem_be_o}, {28'd0, v.ebe});
            chk($sformatf("r%0d.mem_we", i), {31'd0, bus.mem_we_o}, {31'd0, v.ew});
            if (v.ew) chk($sformatf("r%0d.mem_wdata", i), bus.mem_wdata_o, v.ewd);
        end
        if (v.crd) chk($sformatf("r%0d.dm_rdata", i), bus.dm_rdata_o, v.erd);
        if (v.eiv) chk($sformatf("r%0d.if_rdata", i), bus.if_rdata_o, v.rd);
    endtask

    initial begin
        vec_t z;
        z = '{0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0};
        // word load 0x103, immediate gnt
        vecs.push_back('{0,0,0, 1,0,0,'h103,0, 0,0,0,            0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,0,0,'h103,0, 1,0,0,            1,0,'hF,'h100,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,0,0,'h103,0, 0,1,'hDEADBEEF,   0,0,0,0,0, 0,1,1,'hDEADBEEF});
        vecs.push_back(z);
        // byte store 0x42, one cycle of gnt wait, one cycle of rvalid wait
        vecs.push_back('{0,0,0, 1,1,1,'h42,'hA5, 0,0,0,          0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,1,1,'h42,'hA5, 0,0,0,          1,1,'h4,'h40,'hA5A5A5A5, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,1,1,'h42,'hA5, 1,0,0,          1,1,'h4,'h40,'hA5A5A5A5, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,1,1,'h42,'hA5, 0,0,0,          0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,1,1,'h42,'hA5, 0,1,0,          0,0,0,0,0, 0,1,0,0});
        // byte load 0x43 of 0x11223344
        vecs.push_back('{0,0,0, 1,0,1,'h43,0, 0,0,0,             0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,0,1,'h43,0, 1,0,0,             1,0,'h8,'h40,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,0,1,'h43,0, 0,1,'h11223344,    0,0,0,0,0, 0,1,1,'h11});
        // lone fetch clears last_dm
        vecs.push_back('{1,'h200,0, 0,0,0,0,0, 0,0,0,            0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{1,'h200,0, 0,0,0,0,0, 1,0,0,            1,0,'hF,'h200,0, 0,0,0,0});
        vecs.push_back('{1,'h200,0, 0,0,0,0,0, 0,1,'hCAFE0001,   0,0,0,0,0, 1,0,0,0});
        // both requesting with last_dm=0: data first
        vecs.push_back('{1,'h300,0, 1,0,0,'h84,0, 0,0,0,         0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{1,'h300,0, 1,0,0,'h84,0, 1,0,0,         1,0,'hF,'h84,0, 0,0,0,0});
        vecs.push_back('{1,'h300,0, 1,0,0,'h84,0, 0,1,'h55,      0,0,0,0,0, 0,1,1,'h55});
        // both requesting with last_dm=1: fetch first
        vecs.push_back('{1,'h300,0, 1,0,0,'h88,0, 0,0,0,         0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{1,'h300,0, 1,0,0,'h88,0, 1,0,0,         1,0,'hF,'h300,0, 0,0,0,0});
        vecs.push_back('{1,'h300,0, 1,0,0,'h88,0, 0,1,'h1234,    0,0,0,0,0, 1,0,0,0});
        vecs.push_back('{0,0,0, 1,0,0,'h88,0, 0,0,0,             0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,0,0,'h88,0, 1,0,0,             1,0,'hF,'h88,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 1,0,0,'h88,0, 0,1,'h77,          0,0,0,0,0, 0,1,1,'h77});
        // gnt withheld 4 cycles, then flush during IF_WAIT
        vecs.push_back('{1,'h400,0, 0,0,0,0,0, 0,0,0,            0,0,0,0,0, 0,0,0,0});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1,'h400,0, 0,0,0,0,0, 0,0,0,        1,0,'hF,'h400,0, 0,0,0,0});
        vecs.push_back('{1,'h400,0, 0,0,0,0,0, 1,0,0,            1,0,'hF,'h400,0, 0,0,0,0});
        vecs.push_back('{0,0,1, 0,0,0,0,0, 0,0,0,                0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 0,0,0,0,0, 0,1,'h999,            0,0,0,0,0, 0,0,0,0});
        vecs.push_back(z);
        // normal fetch after discard
        vecs.push_back('{1,'h500,0, 0,0,0,0,0, 0,0,0,            0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{1,'h500,0, 0,0,0,0,0, 1,0,0,            1,0,'hF,'h500,0, 0,0,0,0});
        vecs.push_back('{1,'h500,0, 0,0,0,0,0, 0,1,'hABCD,       0,0,0,0,0, 1,0,0,0});
        // flush coincident with rvalid
        vecs.push_back('{1,'h504,0, 0,0,0,0,0, 0,0,0,            0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{1,'h504,0, 0,0,0,0,0, 1,0,0,            1,0,'hF,'h504,0, 0,0,0,0});
        vecs.push_back('{1,'h504,1, 0,0,0,0,0, 0,1,'h5,          0,0,0,0,0, 0,0,0,0});
        vecs.push_back(z);
        // flush in IF_REQ before gnt; stray gnt/rvalid in IDLE ignored
        vecs.push_back('{1,'h600,0, 0,0,0,0,0, 0,0,0,            0,0,0,0,0, 0,0,0,0});
        vecs.push_back('{1,'h600,1, 0,0,0,0,0, 0,0,0,            1,0,'hF,'h600,0, 0,0,0,0});
        vecs.push_back('{0,0,0, 0,0,0,0,0, 1,1,'h7,              0,0,0,0,0, 0,0,0,0});
        vecs.push_back(z);

        drive(z);
        #2;
        chk("rst.mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst.mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst.mem_be", {28'd0, bus.mem_be_o}, 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst.valids", {30'd0, bus.if_valid_o, bus.dm_valid_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check_vec(i, vecs[i]);
        end

        // word store reaching DM_WAIT, then async reset mid-transaction
        @(posedge clk); #1;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_byte_i = 1'b0;
        bus.dm_addr_i = 32'h110; bus.dm_wdata_i = 32'h12345678;
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("seq.store_addr", bus.mem_addr_o, 32'h110);
        chk("seq.store_wdata", bus.mem_wdata_o, 32'h12345678);
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("seq.rst_dm_valid", {31'd0, bus.dm_valid_o}, 32'd0);
        chk("seq.rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("seq.rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
        chk("seq.rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("seq.rst_stall_m", {31'd0, bus.stall_m_o}, 32'd1);
        drive(z);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h700;
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("seq.post_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("seq.post_addr", bus.mem_addr_o, 32'h700);
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hF00D;
        @(negedge clk);
        chk("seq.post_if_valid", {31'd0, bus.if_valid_o}, 32'd1);
        chk("seq.post_if_rdata", bus.if_rdata_o, 32'hF00D);
        @(posedge clk); #1;
        drive(z);
        @(negedge clk);
        chk("seq.post_idle", {31'd0, bus.mem_req_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares a single-ported, variable-latency backing memory between the instruction-fetch port and the data port driven by the control unit's memory-stage signals (memory_o, mem_write_o, byte_address_o). It serialises accesses with a five-state FSM and a req/gnt/rvalid memory handshake, and raises per-stage stall signals to the hazard logic. It sits between the pipeline and the memory model/bus.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width (fixed 32; byte lanes assume 4)

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous reset, active low
- if_req_i  in  1  fetch request, held until if_valid_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_rdata_o  out  32  fetched word
- if_valid_o  out  1  fetch complete (1-cycle pulse)
- flush_i  in  1  cancel outstanding fetch (taken branch/jump)
- dm_req_i  in  1  data access request (memory_o), held until dm_valid_o
- dm_we_i  in  1  store when 1 (mem_write_o)
- dm_byte_i  in  1  byte access when 1 (byte_address_o)
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  32  store data
- dm_rdata_o  out  32  load data
- dm_valid_o  out  1  data access complete (1-cycle pulse)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_WIDTH  word-aligned address
- mem_wdata_o  out  32  write data
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  response/completion (reads and writes)
- mem_rdata_i  in  32  read data
- stall_f_o  out  1  = if_req_i & ~if_valid_o
- stall_m_o  out  1  = dm_req_i & ~dm_valid_o

## Operation
- States: IDLE, IF_REQ, IF_WAIT, DM_REQ, DM_WAIT. One transaction outstanding at a time.
- IDLE: arbitrate, latch selected request's fields into registers, go to X_REQ. Priority: data wins, except when last_dm=1 and if_req_i=1, then fetch wins. last_dm set on every dm completion, cleared on every fetch completion. No request: stay IDLE.
- X_REQ: mem_req_o=1 with registered fields; on mem_gnt_i go X_WAIT, else hold all fields stable.
- X_WAIT: on mem_rvalid_i pulse matching valid output, go IDLE. Back-to-back access: minimum 3 cycles per transaction (IDLE, REQ+gnt, WAIT+rvalid).
- Address: mem_addr_o = addr with bits [1:0] cleared. Word: be=4'b1111, wdata passthrough. Byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
- Load data: word -> dm_rdata_o=mem_rdata_i; byte -> {24'b0, lane addr[1:0] of mem_rdata_i} (sign extension is downstream). Lane and byte flag taken from latched registers. if_rdata_o=mem_rdata_i.
- Store completion also pulses dm_valid_o on mem_rvalid_i; dm_rdata_o don't-care.
- Flush: flush_i in IF_REQ before gnt -> drop mem_req_o next cycle, go IDLE. Flush in IF_WAIT, or flush with gnt in IF_REQ -> set discard flag; on rvalid suppress if_valid_o, clear flag, go IDLE. Flush in IDLE/DM states: no effect on data. Flush the same cycle as rvalid: pulse suppressed.
- Requesters may not change fields while their req is high and valid not yet seen; block does not sample them after latch.

## Timing
- Reset (async, rst_n_i=0): state=IDLE, last_dm=0, discard=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, if_valid_o=0, dm_valid_o=0; stall outputs follow requests combinationally. Reset mid-transaction abandons it; the memory is reset with the block.
- if_valid_o/dm_valid_o combinational from mem_rvalid_i in WAIT state; never both high.
- mem_gnt_i outside REQ states and mem_rvalid_i outside WAIT states are ignored.
- Latency from req high in IDLE to valid: 2 + (gnt wait) + (rvalid wait) cycles.

## Test plan
- Word load, gnt immediate, rvalid next cycle: dm_addr=0x103, rdata=0xDEADBEEF -> mem_addr_o=0x100, be=1111, dm_valid_o at cycle 2, dm_rdata_o=0xDEADBEEF.
- Byte store addr=0x42, wdata=0x000000A5 -> be=0100, mem_wdata_o=0xA5A5A5A5, mem_we_o=1; byte load addr=0x43 of word 0x11223344 -> dm_rdata_o=0x00000011.
- Both requesting, last_dm=0 -> data first; next pair -> fetch first; stall_f_o high until its own valid.
- gnt withheld 4 cycles -> mem_req_o and fields stable throughout; flush_i during IF_WAIT -> rvalid produces no if_valid_o, FSM returns IDLE.
- rst_n_i low mid DM_WAIT -> all outputs reset immediately; after release a new fetch completes normally.
